// File: rtl/t05_sd_arbiter.sv
// SD-card transfer arbiter: sequences SPI read bursts and a terminal write burst, every step paced by serial_clk ticks.
// state | meaning: INIT power-up wait, IDLE arbitrate, RD_CMD/RD_SHIFT/RD_CAP/RD_STOP read burst, WR_CMD/WR_DATA/WR_END write burst, HALT terminal
module t05_sd_arbiter #(
   parameter int unsigned INIT_TICKS = 400,
   parameter int unsigned CMD_TICKS  = 48
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        serial_clk_i,
   input  logic        rd_req_i,
   input  logic [31:0] rd_addr_i,
   input  logic [15:0] rd_count_i,
   output logic [7:0]  rd_data_o,
   output logic        rd_valid_o,
   output logic        rd_done_o,
   input  logic        wr_req_i,
   input  logic [31:0] wr_addr_i,
   input  logic [15:0] wr_count_i,
   input  logic [7:0]  wr_byte_i,
   output logic        wr_take_o,
   output logic        wr_done_o,
   output logic        read_en_o,
   output logic        write_en_o,
   output logic        read_stop_o,
   output logic        writebit_o,
   output logic [31:0] read_address_o,
   output logic [31:0] write_address_o,
   input  logic [7:0]  read_output_i,
   input  logic        finish_i,
   output logic        busy_o,
   output logic        halted_o
);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_RD_CMD, S_RD_SHIFT, S_RD_CAP, S_RD_STOP,
      S_WR_CMD, S_WR_DATA, S_WR_END, S_HALT
   } state_t;

   localparam logic [15:0] INIT_LAST = 16'(INIT_TICKS - 1);
   localparam logic [15:0] CMD_LAST  = 16'(CMD_TICKS - 1);
   localparam logic [15:0] CMD_END   = 16'(CMD_TICKS);

   state_t      state_q;
   logic [15:0] tmr_q;
   logic [15:0] cnt_q;
   logic [7:0]  shift_q;
   logic [7:0]  rd_data_q;
   logic        rd_valid_q, rd_done_q, wr_take_q, wr_done_q;
   logic        read_en_q, write_en_q, read_stop_q, writebit_q;
   logic [31:0] read_address_q, write_address_q;
   logic        busy_q, halted_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= S_INIT;
         tmr_q           <= '0;
         cnt_q           <= '0;
         shift_q         <= '0;
         rd_data_q       <= '0;
         rd_valid_q      <= 1'b0;
         rd_done_q       <= 1'b0;
         wr_take_q       <= 1'b0;
         wr_done_q       <= 1'b0;
         read_en_q       <= 1'b0;
         write_en_q      <= 1'b0;
         read_stop_q     <= 1'b0;
         writebit_q      <= 1'b0;
         read_address_q  <= '0;
         write_address_q <= '0;
         busy_q          <= 1'b1;
         halted_q        <= 1'b0;
      end else begin
         // strobes are one clk wide even when ticks are sparse
         rd_valid_q <= 1'b0;
         rd_done_q  <= 1'b0;
         wr_take_q  <= 1'b0;
         wr_done_q  <= 1'b0;
         if (serial_clk_i) begin
            case (state_q)
               S_INIT: begin
                  if (tmr_q == INIT_LAST) begin
                     tmr_q   <= '0;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               S_IDLE: begin
                  tmr_q <= '0;
                  if (rd_req_i) begin
                     if (rd_count_i == 16'd0) begin
                        rd_done_q <= 1'b1;
                     end else begin
                        read_address_q <= rd_addr_i;
                        cnt_q          <= rd_count_i;
                        read_en_q      <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= S_RD_CMD;
                     end
                  end else if (wr_req_i) begin
                     if (wr_count_i == 16'd0) begin
                        wr_done_q <= 1'b1;
                     end else begin
                        write_address_q <= wr_addr_i;
                        cnt_q           <= wr_count_i;
                        read_stop_q     <= 1'b1;
                        write_en_q      <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= S_WR_CMD;
                     end
                  end
               end
               S_RD_CMD: begin
                  if (tmr_q == CMD_LAST) begin
                     tmr_q     <= '0;
                     read_en_q <= 1'b0;
                     state_q   <= S_RD_SHIFT;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               S_RD_SHIFT: begin
                  if (tmr_q == 16'd7) begin
                     tmr_q     <= '0;
                     read_en_q <= 1'b1;
                     state_q   <= S_RD_CAP;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               S_RD_CAP: begin
                  rd_data_q  <= read_output_i;
                  rd_valid_q <= 1'b1;
                  cnt_q      <= cnt_q - 16'd1;
                  read_en_q  <= 1'b0;
                  tmr_q      <= '0;
                  if (cnt_q == 16'd1) begin
                     read_stop_q <= 1'b1;
                     state_q     <= S_RD_STOP;
                  end else begin
                     state_q <= S_RD_SHIFT;
                  end
               end
               S_RD_STOP: begin
                  if (tmr_q == CMD_LAST) begin
                     tmr_q       <= '0;
                     read_stop_q <= 1'b0;
                     rd_done_q   <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= S_IDLE;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               S_WR_CMD: begin
                  // tmr 0 is the shared read_stop/write_en tick, then CMD_TICKS of write_en alone
                  read_stop_q <= 1'b0;
                  if (tmr_q == CMD_END) begin
                     tmr_q      <= '0;
                     shift_q    <= wr_byte_i;
                     writebit_q <= wr_byte_i[7];
                     wr_take_q  <= 1'b1;
                     state_q    <= S_WR_DATA;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               S_WR_DATA: begin
                  if (tmr_q == 16'd7) begin
                     tmr_q <= '0;
                     if (cnt_q == 16'd1) begin
                        cnt_q      <= '0;
                        write_en_q <= 1'b0;
                        writebit_q <= 1'b0;
                        state_q    <= S_WR_END;
                     end else begin
                        cnt_q      <= cnt_q - 16'd1;
                        shift_q    <= wr_byte_i;
                        writebit_q <= wr_byte_i[7];
                        wr_take_q  <= 1'b1;
                     end
                  end else begin
                     tmr_q      <= tmr_q + 16'd1;
                     writebit_q <= shift_q[6];
                     shift_q    <= {shift_q[6:0], 1'b0};
                  end
               end
               S_WR_END: begin
                  if (finish_i) begin
                     wr_done_q <= 1'b1;
                     halted_q  <= 1'b1;
                     state_q   <= S_HALT;
                  end
               end
               S_HALT: begin
                  state_q <= S_HALT;
               end
               default: begin
                  state_q <= S_INIT;
               end
            endcase
         end
      end
   end

   assign rd_data_o       = rd_data_q;
   assign rd_valid_o      = rd_valid_q;
   assign rd_done_o       = rd_done_q;
   assign wr_take_o       = wr_take_q;
   assign wr_done_o       = wr_done_q;
   assign read_en_o       = read_en_q;
   assign write_en_o      = write_en_q;
   assign read_stop_o     = read_stop_q;
   assign writebit_o      = writebit_q;
   assign read_address_o  = read_address_q;
   assign write_address_o = write_address_q;
   assign busy_o          = busy_q;
   assign halted_o        = halted_q;

endmodule

// File: doc/t05_sd_arbiter.md
T05_SD_ARBITER -- requirements
Module: t05_sd_arbiter

Interface
REQ-001 Parameter: INIT_TICKS, default 400, serial_clk ticks waited after reset before any request is granted.
REQ-002 Parameter: CMD_TICKS, default 48, serial_clk ticks per command frame.
REQ-003 clk  in  1  system clock; the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 serial_clk  in  1  one-clk-wide tick enable; all tick counters advance only on cycles where serial_clk=1.
REQ-006 rd_req / rd_addr / rd_count  in  1/32/16  read request, start block address, byte count; held stable until rd_done.
REQ-007 rd_data / rd_valid / rd_done  out  8/1/1  received byte, one-clk byte strobe, one-clk burst-complete strobe.
REQ-008 wr_req / wr_addr / wr_count / wr_byte  in  1/32/16/8  write request, address, byte count, current byte; held stable until wr_done.
REQ-009 wr_take / wr_done  out  1/1  one-clk strobe: wr_byte sampled this cycle, advance it; one-clk write-complete strobe.
REQ-010 read_en / write_en / read_stop / writebit  out  1 each  SPI controller controls.
REQ-011 read_address / write_address  out  32 each  SPI command addresses.
REQ-012 read_output / finish  in  8/1  SPI received byte (valid while read_en=1); SPI done flag.
REQ-013 busy / halted  out  1/1  not in IDLE; in terminal HALT state.

Function
REQ-014 States: INIT, IDLE, RD_CMD, RD_SHIFT, RD_CAP, RD_STOP, WR_CMD, WR_DATA, WR_END, HALT.
REQ-015 A "tick" is a clk cycle with serial_clk=1; outputs are registered and update only on ticks, so each output level is seen by the SPI for whole ticks.
REQ-016 INIT: all SPI controls 0; after INIT_TICKS ticks -> IDLE.
REQ-017 IDLE arbitration, fixed priority: rd_req wins over wr_req; wr_req granted only when rd_req=0 (write is terminal, SPI cannot return to read).
REQ-018 rd_count=0 or wr_count=0: request completes with its done strobe on the grant cycle, no SPI activity, back to IDLE.
REQ-019 Read grant: latch rd_addr into read_address, load byte counter with rd_count -> RD_CMD.
REQ-020 RD_CMD: read_en=1 for exactly CMD_TICKS ticks -> RD_SHIFT.
REQ-021 RD_SHIFT: read_en=0, read_stop=0 for exactly 8 ticks -> RD_CAP.
REQ-022 RD_CAP: read_en=1 for 1 tick; on that tick latch read_output into rd_data, pulse rd_valid, decrement counter; counter reaches 0 -> RD_STOP, else -> RD_SHIFT (byte period 9 ticks).
REQ-023 RD_STOP: read_stop=1, read_en=0 for CMD_TICKS ticks; then rd_done pulse -> IDLE.
REQ-024 Write grant: latch wr_addr into write_address, load counter with wr_count; read_stop=1 and write_en=1 together on the first tick -> WR_CMD.
REQ-025 WR_CMD: write_en=1, read_stop=0 for CMD_TICKS ticks -> WR_DATA.
REQ-026 WR_DATA: per byte, wr_take pulse on the first tick, sample wr_byte; writebit drives bits 7..0 MSB-first, one bit per tick, 8 ticks per byte; after last byte -> WR_END.
REQ-027 WR_END: write_en=0, writebit=0; wait for finish=1, then wr_done pulse -> HALT.
REQ-028 HALT: terminal until rst; all requests ignored, halted=1, busy=1.
REQ-029 Requests deasserted mid-transfer are ignored; a started sequence always runs to completion.
REQ-030 Counters 16-bit unsigned, no wrap: rd_count/wr_count=65535 valid.
REQ-031 serial_clk held 0: all state and outputs frozen.

Reset
REQ-032 rst=1 on any clk edge, mid-operation included: state INIT, counters 0, all outputs 0 except busy=1; read_address/write_address/rd_data 0.

Verification
REQ-033 Reset, INIT_TICKS=400, serial_clk every cycle: busy=1 for 400 cycles, then busy=0; no SPI control toggles.
REQ-034 rd_req, rd_addr=0x00000010, rd_count=2, read_output=0xA5: read_en high 48 ticks, 8 low, 1 high (rd_valid, rd_data=0xA5), repeat; read_stop 48 ticks; single rd_done.
REQ-035 rd_req and wr_req both high: read served first; write starts only after rd_done and rd_req dropped.
REQ-036 wr_count=1, wr_byte=0xC3: read_stop+write_en 1 tick, write_en 48 ticks, writebit 1,1,0,0,0,0,1,1; one wr_take; wr_done after finish; halted=1.
REQ-037 serial_clk pulsed every 4th cycle: all tick counts identical to REQ-034; no output change on non-tick cycles.
REQ-038 rst asserted during RD_SHIFT: next cycle state INIT, read_en=0, no rd_valid/rd_done.
